// File: rtl/shift_sub_div_sign.sv
// Sequential restoring divider (start/ready/done handshake), one quotient bit per cycle.
// Define DIV_SIGNED_EN for two's-complement operands; the default build divides unsigned operands.
module shift_sub_div_sign #(
  parameter int N    = 8,
  parameter int M    = 8,
  parameter int logN = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [M-1:0] B,
  output logic [N-1:0] Q,
  output logic [M-1:0] R,
  output logic         ready,
  output logic         done,
  output logic         div_zero,
  output logic         ovf
);

  typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, DONE} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   aReg_q, aReg_d;
  logic [M-1:0]   bReg_q, bReg_d;
  logic [N-1:0]   quoShift_q, quoShift_d;
  logic [M-1:0]   bMag_q, bMag_d;
  logic [M-1:0]   partRem_q, partRem_d;
  logic [logN-1:0] count_q, count_d;
  logic           qNeg_q, qNeg_d;
  logic           rNeg_q, rNeg_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [M-1:0]   rem_q, rem_d;
  logic           divZero_q, divZero_d;
  logic           ovf_q, ovf_d;

  logic           aNeg, bNeg, isOvf;
  logic [N-1:0]   aMag;
  logic [M-1:0]   bMagC;
  logic [M-1:0]   aLow;
  logic [M:0]     shifted;
  logic [M+1:0]   diff;
  logic           take;

`ifdef DIV_SIGNED_EN
  assign aNeg  = aReg_q[N-1];
  assign bNeg  = bReg_q[M-1];
  assign aMag  = aNeg ? -aReg_q : aReg_q;
  assign bMagC = bNeg ? -bReg_q : bReg_q;
  assign isOvf = (aReg_q == {1'b1, {(N-1){1'b0}}}) && (bReg_q == {M{1'b1}});
`else
  assign aNeg  = 1'b0;
  assign bNeg  = 1'b0;
  assign aMag  = aReg_q;
  assign bMagC = bReg_q;
  assign isOvf = 1'b0;
`endif

  generate
    if (M <= N) begin : gLowTrunc
      assign aLow = aReg_q[M-1:0];
    end else begin : gLowExt
      assign aLow = {{(M-N){1'b0}}, aReg_q};
    end
  endgenerate

  // The partial remainder always stays below |B|, so M bits hold it between iterations.
  assign shifted = {partRem_q, quoShift_q[N-1]};
  assign diff    = {1'b0, shifted} - {2'b00, bMag_q};
  assign take    = ~diff[M+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      aReg_q     <= '0;
      bReg_q     <= '0;
      quoShift_q <= '0;
      bMag_q     <= '0;
      partRem_q  <= '0;
      count_q    <= '0;
      qNeg_q     <= 1'b0;
      rNeg_q     <= 1'b0;
      quo_q      <= '0;
      rem_q      <= '0;
      divZero_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      aReg_q     <= aReg_d;
      bReg_q     <= bReg_d;
      quoShift_q <= quoShift_d;
      bMag_q     <= bMag_d;
      partRem_q  <= partRem_d;
      count_q    <= count_d;
      qNeg_q     <= qNeg_d;
      rNeg_q     <= rNeg_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      divZero_q  <= divZero_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    aReg_d     = aReg_q;
    bReg_d     = bReg_q;
    quoShift_d = quoShift_q;
    bMag_d     = bMag_q;
    partRem_d  = partRem_q;
    count_d    = count_q;
    qNeg_d     = qNeg_q;
    rNeg_d     = rNeg_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    divZero_d  = divZero_q;
    ovf_d      = ovf_q;
    ready      = 1'b0;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          aReg_d  = A;
          bReg_d  = B;
          state_d = LOAD;
        end
      end
      LOAD: begin
        quoShift_d = aMag;
        bMag_d     = bMagC;
        qNeg_d     = aNeg ^ bNeg;
        rNeg_d     = aNeg;
        partRem_d  = '0;
        count_d    = '0;
        state_d    = ITER;
      end
      ITER: begin
        partRem_d  = take ? diff[M-1:0] : shifted[M-1:0];
        quoShift_d = {quoShift_q[N-2:0], take};
        count_d    = count_q + 1'b1;
        if (count_q == logN'(N-1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // A zero divisor overrides the iteration result with a fixed pattern.
        if (bReg_q == '0) begin
          quo_d     = '1;
          rem_d     = aLow;
          divZero_d = 1'b1;
          ovf_d     = 1'b0;
        end else begin
          quo_d     = qNeg_q ? -quoShift_q : quoShift_q;
          rem_d     = rNeg_q ? -partRem_q : partRem_q;
          divZero_d = 1'b0;
          ovf_d     = isOvf;
        end
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign Q        = quo_q;
  assign R        = rem_q;
  assign div_zero = divZero_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_shift_sub_div_sign.sv
// Scoreboard bench for shift_sub_div_sign: drivers push expected results, a negedge monitor pops on done.
// Expected values follow DIV_SIGNED_EN exactly as the design is built.
module tb_shift_sub_div_sign;

  localparam int N = 8;
  localparam int M = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] A;
  logic [M-1:0] B;
  logic [N-1:0] Q;
  logic [M-1:0] R;
  logic         ready, done, div_zero, ovf;

  typedef struct {
    logic [N-1:0] q;
    logic [M-1:0] r;
    logic         dz;
    logic         ov;
    int           cap;
  } exp_t;

  exp_t sbQ[$];
  exp_t monE;
  int   cyc = 0;
  int   checkCount = 0;
  int   passCount = 0;
  int   prevCap;
  logic busyReady;

  shift_sub_div_sign #(.N(N), .M(M), .logN(4)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .Q(Q), .R(R), .ready(ready), .done(done),
    .div_zero(div_zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checkCount++;
    if (act === expv) passCount++;
    else $display("[TB] FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, expv, cyc);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedDone", 32'd1, 32'd0);
      end else begin
        monE = sbQ.pop_front();
        checkOutput("Q", 32'(Q), 32'(monE.q));
        checkOutput("R", 32'(R), 32'(monE.r));
        checkOutput("div_zero", 32'(div_zero), 32'(monE.dz));
        checkOutput("ovf", 32'(ovf), 32'(monE.ov));
        checkOutput("latency", 32'(cyc - monE.cap), 32'(N + 2));
      end
    end
  end

  task automatic waitReady();
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) checkOutput("readyTimeout", 32'(ready), 32'd1);
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sbQ.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sbQ.size() != 0) begin
      checkOutput("drainTimeout", 32'(sbQ.size()), 32'd0);
      sbQ.delete();
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] a, input logic [M-1:0] b,
                               input logic [N-1:0] eq, input logic [M-1:0] er,
                               input logic edz, input logic eov);
    waitReady();
    A = a;
    B = b;
    start = 1'b1;
    sbQ.push_back('{eq, er, edz, eov, cyc + 1});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic runOp(input logic [N-1:0] a, input logic [M-1:0] b,
                       input logic [N-1:0] eq, input logic [M-1:0] er,
                       input logic edz, input logic eov);
    applyStimulus(a, b, eq, er, edz, eov);
    waitDrain();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("resetQ", 32'(Q), 32'd0);
    checkOutput("resetR", 32'(R), 32'd0);
    checkOutput("resetFlags", {30'd0, div_zero, ovf}, 32'd0);
    checkOutput("resetDone", 32'(done), 32'd0);
    checkOutput("resetReady", 32'(ready), 32'd1);

    // First operation also checks ready stays low from capture through DONE.
    applyStimulus(8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0);
    busyReady = 1'b0;
    for (int i = 0; i < N + 3; i++) begin
      busyReady = busyReady | ready;
      if (i < N + 2) @(negedge clk);
    end
    checkOutput("readyLowBusy", 32'(busyReady), 32'd0);
    @(negedge clk);
    checkOutput("readyAfterDone", 32'(ready), 32'd1);
    checkOutput("donePulseWidth", 32'(done), 32'd0);
    waitDrain();

`ifdef DIV_SIGNED_EN
    $display("[TB] signed build");
    runOp(8'h9C, 8'd7,  8'hF2, 8'hFE, 1'b0, 1'b0);
    runOp(8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0);
    runOp(8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0);
    runOp(8'd5,  8'd0,  8'hFF, 8'h05, 1'b1, 1'b0);
    runOp(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1);
    runOp(8'hC8, 8'd7,  8'hF8, 8'h00, 1'b0, 1'b0);
    runOp(8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0);
`else
    $display("[TB] unsigned build");
    runOp(8'h9C, 8'd7,  8'h16, 8'h02, 1'b0, 1'b0);
    runOp(8'd100, 8'hF9, 8'h00, 8'h64, 1'b0, 1'b0);
    runOp(8'h9C, 8'hF9, 8'h00, 8'h9C, 1'b0, 1'b0);
    runOp(8'd5,  8'd0,  8'hFF, 8'h05, 1'b1, 1'b0);
    runOp(8'h80, 8'hFF, 8'h00, 8'h80, 1'b0, 1'b0);
    runOp(8'hC8, 8'd7,  8'h1C, 8'h04, 1'b0, 1'b0);
    runOp(8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0);
`endif

    // A start pulse while busy must be ignored entirely.
    applyStimulus(8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    A = 8'd1;
    B = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDrain();
    repeat (N + 6) @(negedge clk);
    checkOutput("busyStartHoldQ", 32'(Q), 32'h0E);
    checkOutput("busyStartHoldR", 32'(R), 32'h02);

    // Reset while the iteration counter sits at 3; no done may follow.
    waitReady();
    A = 8'd20;
    B = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midResetQ", 32'(Q), 32'd0);
    checkOutput("midResetR", 32'(R), 32'd0);
    checkOutput("midResetFlags", {30'd0, div_zero, ovf}, 32'd0);
    checkOutput("midResetReady", 32'(ready), 32'd1);
    repeat (N + 6) @(negedge clk);

    // start held high: three launches, each one N+4 cycles after the previous.
    for (int k = 0; k < 3; k++) begin
      waitReady();
      if (k > 0) checkOutput("b2bSpacing", 32'(cyc + 1 - prevCap), 32'(N + 4));
      prevCap = cyc + 1;
      start = 1'b1;
      case (k)
        0: begin A = 8'd20;  B = 8'd3; sbQ.push_back('{8'h06, 8'h02, 1'b0, 1'b0, cyc + 1}); end
`ifdef DIV_SIGNED_EN
        1: begin A = 8'hF7;  B = 8'd4; sbQ.push_back('{8'hFE, 8'hFF, 1'b0, 1'b0, cyc + 1}); end
`else
        1: begin A = 8'hF7;  B = 8'd4; sbQ.push_back('{8'h3D, 8'h03, 1'b0, 1'b0, cyc + 1}); end
`endif
        default: begin A = 8'd127; B = 8'd1; sbQ.push_back('{8'h7F, 8'h00, 1'b0, 1'b0, cyc + 1}); end
      endcase
      @(negedge clk);
    end
    start = 1'b0;
    waitDrain();
    repeat (N + 6) @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
